pmt_timebin_counter: RTL and testbench
======================================

# pmt_timebin_counter

Counts photomultiplier (PMT) discriminator edges into consecutive fixed-length time bins after a single-cycle start pulse from the upstream trigger/pulse stage. Each completed bin count is pushed into a small output FIFO and streamed to the readout side over a valid/ready handshake. The block sits between the start-pulse generator and the host readout logic in the PMT_Timebin_Counts design.

## Interface
- BIN_CYCLES, 5000, clock cycles per bin (100 µs at 50 MHz); must be ≥ 2
- NUM_BINS, 16, bins per run; must be ≥ 1
- CNT_W, 16, width of one bin count
- FIFO_DEPTH, 4, output FIFO entries; power of two
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  single-cycle run trigger from upstream pulse stage
- pmt_in  in  1  raw PMT discriminator output, asynchronous to clock
- out_data  out  CNT_W  bin count at FIFO head
- out_index  out  $clog2(NUM_BINS)  bin number of out_data
- out_last  out  1  high when out_index == NUM_BINS-1
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head when out_valid && out_ready
- busy  out  1  high while a run is counting
- dropped  out  1  sticky: at least one bin lost to a full FIFO this run

## Operation
- pmt_in passes a 2-flop synchronizer, then rising-edge detect; one detected edge = one count.
- States: IDLE, COUNT. Reset → IDLE.
- IDLE: start=1 → COUNT; bin index, cycle counter, bin count cleared to 0; dropped cleared.
- COUNT: cycle counter runs 0..BIN_CYCLES-1. Each detected edge increments bin count; count saturates at 2^CNT_W-1, never wraps.
- Cycle counter == BIN_CYCLES-1: bin closes. Edge detected in that cycle is included in the closing bin. Closed count + index pushed to FIFO; bin count restarts at 0 in the next cycle.
- FIFO full at bin close: bin discarded, dropped set (sticky until next accepted start); counting continues.
- Bin NUM_BINS-1 closes → IDLE.
- start while in COUNT: ignored.
- FIFO is independent of state: draining continues in IDLE; a new run may start with undrained entries.
- Push and pop in the same cycle on a full FIFO: pop first, push succeeds, no drop.

## Timing
- Reset values: out_data 0, out_index 0, out_last 0, out_valid 0, busy 0, dropped 0; FIFO empty.
- start sampled at cycle t → busy=1 from t+1; cycle counter = 0 at t+1.
- Bin k closes at cycle t+(k+1)·BIN_CYCLES; pushed entry visible (out_valid=1) in the next cycle if FIFO was empty.
- busy falls the cycle after the last bin closes.
- pmt_in edge → counted 3 cycles later (2 sync + edge-detect register).
- out_data/out_index/out_last stable while out_valid && !out_ready.
- Reset mid-run: immediate return to IDLE, FIFO flushed, in-progress counts lost.

## Configuration
- TIMEBIN_LED_EN defined: adds output led (1 bit, reset 0) toggling once per completed run (cycle busy falls), as an operator heartbeat.
- Undefined: no led port, no toggle register.

## Structure
- Package pmt_timebin_pkg: state enum (IDLE, COUNT), default parameter constants, FIFO entry typedef {index, count}.
- Sub-module pmt_bin_fifo: synchronous FIFO, FIFO_DEPTH entries, push/pop/full/empty, simultaneous push+pop on full allowed.

## Test plan
- BIN_CYCLES=10, NUM_BINS=4, out_ready=1, 3 pmt pulses per bin → four outputs count=3, index 0..3, out_last only on index 3; busy high 40 cycles.
- CNT_W=4, 20 pulses in bin 0 → out_data=15 (saturated), bin 1 starts at 0.
- Pulse timed to be detected exactly on cycle BIN_CYCLES-1 of bin 0 → counted in bin 0, bin 1 unaffected.
- out_ready=0 whole run, FIFO_DEPTH=2, NUM_BINS=4 → two entries held (index 0,1), dropped=1; next start clears dropped.
- start pulsed again mid-run → ignored, run ends at original time with NUM_BINS outputs.
- reset asserted mid-bin 2 → all outputs 0 next cycle, out_valid=0; subsequent start runs cleanly from bin 0.

Source files
------------

// File: rtl/pmt_timebin_pkg.sv
// Shared types and defaults for the PMT time-bin counter.
//   state_t      : run-control FSM states (IDLE, COUNT)
//   DEF_*        : default parameter values used by the top and the FIFO
//   bin_entry_t  : FIFO entry layout {index, count} at the default widths
//   idx_width()  : width of a counter for n states, never less than 1 bit
package pmt_timebin_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam int DEF_BIN_CYCLES = 5000;
  localparam int DEF_NUM_BINS   = 16;
  localparam int DEF_CNT_W      = 16;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_IDX_W      = $clog2(DEF_NUM_BINS);

  typedef struct packed {
    logic [DEF_IDX_W-1:0] index;
    logic [DEF_CNT_W-1:0] count;
  } bin_entry_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pmt_timebin_counter_if.sv
// Readout stream of completed bins.
// Handshake: the master holds out_data/out_index/out_last stable while
// out_valid is high; an entry is transferred on every rising clock edge
// where out_valid && out_ready. out_ready may be driven at any time and
// has no combinational path back to out_valid.
//   out_data  : bin count at FIFO head
//   out_index : bin number of out_data
//   out_last  : high when out_index is the final bin of a run
//   out_valid : FIFO head valid
//   out_ready : consumer accepts the head
interface pmt_timebin_counter_if #(
  parameter int CNT_W = 16,
  parameter int IDX_W = 4
);
  logic [CNT_W-1:0] out_data;
  logic [IDX_W-1:0] out_index;
  logic             out_last;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output out_data, out_index, out_last, out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data, out_index, out_last, out_valid,
    output out_ready
  );
endinterface

// File: rtl/pmt_bin_fifo.sv
// Synchronous FIFO holding closed bins until the readout side takes them.
//   clock, reset : system clock, asynchronous active-high reset (empties FIFO)
//   push, push_data : write request; accepted when not full, or when full
//                     and a pop happens in the same cycle
//   pop, pop_data   : read request (ignored when empty), head entry
//   full, empty     : occupancy flags
module pmt_bin_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          do_push, do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the read side never exposes an empty slot.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pmt_timebin_counter.sv
// Counts PMT discriminator edges into NUM_BINS consecutive bins of
// BIN_CYCLES clocks after a start pulse and streams each closed bin out.
//   clock, reset : system clock, asynchronous active-high reset
//   start        : single-cycle run trigger (ignored while counting)
//   pmt_in       : raw discriminator output, asynchronous to clock
//   stream       : readout stream (master side), see pmt_timebin_counter_if
//   busy         : high while a run is counting
//   dropped      : sticky, a bin was lost to a full FIFO during this run
//   dbg_state    : current FSM state
//   led          : only with TIMEBIN_LED_EN defined; toggles once per
//                  completed run
module pmt_timebin_counter
  import pmt_timebin_pkg::*;
#(
  parameter int BIN_CYCLES = DEF_BIN_CYCLES,
  parameter int NUM_BINS   = DEF_NUM_BINS,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   start,
  input  logic   pmt_in,
  pmt_timebin_counter_if.master stream,
  output logic   busy,
  output logic   dropped,
  output state_t dbg_state
`ifdef TIMEBIN_LED_EN
  ,
  output logic   led
`endif
);
  localparam int IDX_W = idx_width(NUM_BINS);
  localparam int CYC_W = idx_width(BIN_CYCLES);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIN_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BINS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef struct packed {
    logic [IDX_W-1:0] index;
    logic [CNT_W-1:0] count;
  } entry_t;

  // Synchronizer (sync1, sync2) plus the edge-detect register sync3.
  logic sync1, sync2, sync3, pmt_edge;

  state_t           state_q, state_d;
  logic [CYC_W-1:0] cyc_q;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] cnt_q, cnt_inc;
  logic             bin_close, last_close, drop;

  entry_t fifo_in, fifo_head;
  logic   fifo_full, fifo_empty, pop;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= pmt_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign pmt_edge   = sync2 && !sync3;
  assign bin_close  = (state_q == COUNT) && (cyc_q == CYC_LAST);
  assign last_close = bin_close && (idx_q == IDX_LAST);
  // Saturating increment; also the value pushed at close, so an edge seen
  // in the closing cycle lands in the closing bin.
  assign cnt_inc    = (pmt_edge && (cnt_q != CNT_MAX)) ? cnt_q + CNT_W'(1) : cnt_q;

  // FSM: state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = COUNT;
      COUNT:   if (last_close) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy      = (state_q == COUNT);
    dbg_state = state_q;
  end

  // Bin datapath
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cyc_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      dropped <= 1'b0;
    end else if (state_q == IDLE) begin
      if (start) begin
        cyc_q   <= '0;
        idx_q   <= '0;
        cnt_q   <= '0;
        dropped <= 1'b0;
      end
    end else if (bin_close) begin
      cyc_q <= '0;
      cnt_q <= '0;
      idx_q <= last_close ? '0 : idx_q + IDX_W'(1);
      if (drop) dropped <= 1'b1;
    end else begin
      cyc_q <= cyc_q + CYC_W'(1);
      cnt_q <= cnt_inc;
    end
  end

  assign pop     = stream.out_valid && stream.out_ready;
  assign drop    = bin_close && fifo_full && !pop;
  assign fifo_in = '{index: idx_q, count: cnt_inc};

  pmt_bin_fifo #(
    .W     (IDX_W + CNT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (bin_close),
    .push_data (fifo_in),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Head fields read as zero while nothing is valid.
  assign stream.out_valid = !fifo_empty;
  assign stream.out_data  = fifo_empty ? '0 : fifo_head.count;
  assign stream.out_index = fifo_empty ? '0 : fifo_head.index;
  assign stream.out_last  = !fifo_empty && (fifo_head.index == IDX_LAST);

`ifdef TIMEBIN_LED_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)           led <= 1'b0;
    else if (last_close) led <= ~led;
  end
`endif

endmodule

// File: tb/tb_pmt_timebin_counter.sv
// Directed bench for pmt_timebin_counter: 40-cycle bins, 4 bins per run,
// 4-bit counts, 2-entry FIFO. Entries are packed as {last, index, data}.
module tb_pmt_timebin_counter;
  import pmt_timebin_pkg::*;

  localparam int BC = 40;
  localparam int NB = 4;
  localparam int CW = 4;
  localparam int FD = 2;
  localparam int IW = 2;

  logic   clock = 1'b0;
  logic   reset, start, pmt_in;
  logic   busy, dropped;
  state_t dbg_state;
`ifdef TIMEBIN_LED_EN
  logic   led;
`endif

  pmt_timebin_counter_if #(.CNT_W(CW), .IDX_W(IW)) stream ();

  pmt_timebin_counter #(
    .BIN_CYCLES (BC),
    .NUM_BINS   (NB),
    .CNT_W      (CW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .pmt_in    (pmt_in),
    .stream    (stream),
    .busy      (busy),
    .dropped   (dropped),
    .dbg_state (dbg_state)
`ifdef TIMEBIN_LED_EN
    ,
    .led       (led)
`endif
  );

  // Clock / reset block
  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;
  int busy_cnt = 0;

  logic [6:0] obs_q[$];
  logic [6:0] exp_q[$];

  // Monitor: records every accepted entry and counts busy cycles.
  always @(negedge clock) begin
    if (busy) busy_cnt++;
    if (!reset && stream.out_valid && stream.out_ready)
      obs_q.push_back({stream.out_last, stream.out_index, stream.out_data});
  end

  // Driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse();
    pmt_in = 1'b1;
    tick();
    pmt_in = 1'b0;
    tick();
  endtask

  // Leaves the bench in the first counting cycle (bin 0, cycle 0).
  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic expect_entry(input logic last, input logic [1:0] idx, input logic [3:0] data);
    exp_q.push_back({last, idx, data});
  endtask

  // Scoreboard: compares recorded entries against the expected queue.
  task automatic compare_sb(input string tag);
    logic [6:0] e, g;
    check({tag, "_size"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (obs_q.size() > 0) ? obs_q.pop_front() : 7'bx;
      check(tag, {25'd0, g}, {25'd0, e});
    end
    obs_q.delete();
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    pmt_in = 1'b0;
    stream.out_ready = 1'b1;
    idle(3);
    check("rst_valid", stream.out_valid, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    tick();
    check("rst_data", stream.out_data, 0);
    check("rst_index", stream.out_index, 0);
    check("rst_last", stream.out_last, 0);
    check("rst_valid2", stream.out_valid, 0);
    check("rst_dropped", dropped, 0);
    check("rst_state", dbg_state, IDLE);

    // Basic run: 3 pulses per bin, consumer always ready.
    busy_cnt = 0;
    start_run();
    check("t1_busy_rise", busy, 1);
    for (int k = 0; k < NB; k++) begin
      repeat (3) pulse();
      idle(BC - 6);
    end
    check("t1_busy_fall", busy, 0);
    idle(3);
    check("t1_busy_cycles", busy_cnt, 160);
    check("t1_dropped", dropped, 0);
    expect_entry(1'b0, 2'd0, 4'd3);
    expect_entry(1'b0, 2'd1, 4'd3);
    expect_entry(1'b0, 2'd2, 4'd3);
    expect_entry(1'b1, 2'd3, 4'd3);
    compare_sb("t1_entry");

    // Saturation: 18 edges in bin 0, 2 in bin 1.
    start_run();
    repeat (18) pulse();
    idle(4);
    repeat (2) pulse();
    idle(BC - 4);
    idle(2 * BC + 3);
    expect_entry(1'b0, 2'd0, 4'd15);
    expect_entry(1'b0, 2'd1, 4'd2);
    expect_entry(1'b0, 2'd2, 4'd0);
    expect_entry(1'b1, 2'd3, 4'd0);
    compare_sb("t2_entry");

    // Boundary: edge detected on the last cycle of bin 0, and one on the
    // first cycle of bin 2.
    start_run();
    idle(37);
    pulse();
    idle(39);
    pulse();
    idle(80 + 3);
    expect_entry(1'b0, 2'd0, 4'd1);
    expect_entry(1'b0, 2'd1, 4'd0);
    expect_entry(1'b0, 2'd2, 4'd1);
    expect_entry(1'b1, 2'd3, 4'd0);
    compare_sb("t3_entry");

    // Backpressure: consumer stalled for the whole run.
    stream.out_ready = 1'b0;
    start_run();
    pulse();
    idle(BC - 2);
    repeat (2) pulse();
    idle(116 + 5);
    check("t4_valid", stream.out_valid, 1);
    check("t4_index", stream.out_index, 0);
    check("t4_data", stream.out_data, 1);
    check("t4_last", stream.out_last, 0);
    check("t4_dropped", dropped, 1);
    check("t4_busy", busy, 0);
    idle(4);
    check("t4_hold_data", stream.out_data, 1);
    check("t4_hold_index", stream.out_index, 0);
    stream.out_ready = 1'b1;
    idle(3);
    check("t4_drained", stream.out_valid, 0);
    check("t4_dropped_sticky", dropped, 1);
    expect_entry(1'b0, 2'd0, 4'd1);
    expect_entry(1'b0, 2'd1, 4'd2);
    compare_sb("t4_entry");

    // Second start mid-run is ignored; new start clears dropped.
    busy_cnt = 0;
    start_run();
    check("t5_dropped_clr", dropped, 0);
    idle(59);
    start_run();
    idle(100);
    check("t5_busy_fall", busy, 0);
    idle(3);
    check("t5_busy_cycles", busy_cnt, 160);
    expect_entry(1'b0, 2'd0, 4'd0);
    expect_entry(1'b0, 2'd1, 4'd0);
    expect_entry(1'b0, 2'd2, 4'd0);
    expect_entry(1'b1, 2'd3, 4'd0);
    compare_sb("t5_entry");

    // Reset in the middle of bin 2 with entries waiting.
    stream.out_ready = 1'b0;
    start_run();
    repeat (2) pulse();
    idle(85);
    check("t6_pre_valid", stream.out_valid, 1);
    check("t6_pre_data", stream.out_data, 2);
    check("t6_pre_state", dbg_state, COUNT);
    check("t6_pre_dropped", dropped, 0);
    reset = 1'b1;
    tick();
    check("t6_rst_valid", stream.out_valid, 0);
    check("t6_rst_data", stream.out_data, 0);
    check("t6_rst_index", stream.out_index, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_state", dbg_state, IDLE);
    reset = 1'b0;
    stream.out_ready = 1'b1;
    idle(2);
    check("t6_flushed", stream.out_valid, 0);
    obs_q.delete();
    start_run();
    pulse();
    idle(158 + 3);
    check("t6_dropped", dropped, 0);
    expect_entry(1'b0, 2'd0, 4'd1);
    expect_entry(1'b0, 2'd1, 4'd0);
    expect_entry(1'b0, 2'd2, 4'd0);
    expect_entry(1'b1, 2'd3, 4'd0);
    compare_sb("t6_entry");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
